// File: rtl/msrv32_fetch_unit_if.sv
// Bus bundle between the msrv32 fetch unit, instruction memory and decode.
// Decode handshake: an instruction transfers on a rising edge where instr_valid_out
// and instr_ready_in are both high; instr_out/pc_out hold while valid and not ready.
interface msrv32_fetch_unit_if;
  logic        branch_taken_in;
  logic [31:0] iaddr_in;
  logic        trap_taken_in;
  logic [31:0] trap_addr_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        flush_out;
  logic        misaligned_instr_out;
  logic [1:0]  state_dbg;

  modport master (
    input  branch_taken_in, iaddr_in, trap_taken_in, trap_addr_in,
    input  imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
    output imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out,
    output flush_out, misaligned_instr_out, state_dbg
  );

  modport slave (
    output branch_taken_in, iaddr_in, trap_taken_in, trap_addr_in,
    output imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
    input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out,
    input  flush_out, misaligned_instr_out, state_dbg
  );
endinterface

// File: rtl/msrv32_fetch_unit.sv
// Program counter and single-outstanding instruction fetch for the msrv32 core.
// Handles trap/branch redirects, drops killed responses and parks on misaligned targets.
module msrv32_fetch_unit #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] PC_INC    = 32'd4
) (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_n_in,
  msrv32_fetch_unit_if.master        bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_MISAL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        kill_q, kill_d;
  logic        flush_q, flush_d;
  logic        started_q;
  logic [31:0] branch_target;

  assign branch_target = bus.iaddr_in & ~32'h0000_0001;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q   <= S_REQ;
      pc_q      <= BOOT_ADDR;
      pc_out_q  <= BOOT_ADDR;
      instr_q   <= NOP;
      kill_q    <= 1'b0;
      flush_q   <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      instr_q   <= instr_d;
      kill_q    <= kill_d;
      flush_q   <= flush_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    kill_d   = kill_q;
    flush_d  = 1'b0;
    case (state_q)
      S_REQ: begin
        // started_q keeps the request low for the first cycle out of reset
        if (started_q) begin
          if (bus.trap_taken_in) begin
            pc_d    = bus.trap_addr_in;
            flush_d = 1'b1;
            if (bus.imem_gnt_in) begin
              state_d = S_WAIT;
              kill_d  = 1'b1;
            end
          end else if (bus.imem_gnt_in) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.trap_taken_in) begin
          pc_d    = bus.trap_addr_in;
          flush_d = 1'b1;
          // a response landing with the trap is consumed here, so nothing is left to kill
          if (bus.imem_rvalid_in) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (bus.imem_rvalid_in) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d  = bus.imem_rdata_in;
            pc_out_d = pc_q;
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.trap_taken_in) begin
          pc_d    = bus.trap_addr_in;
          flush_d = 1'b1;
          state_d = S_REQ;
        end else if (bus.instr_ready_in) begin
          if (bus.branch_taken_in && bus.iaddr_in[1]) begin
            state_d = S_MISAL;
          end else if (bus.branch_taken_in) begin
            pc_d    = branch_target;
            flush_d = 1'b1;
            state_d = S_REQ;
          end else begin
            pc_d    = pc_q + PC_INC;
            state_d = S_REQ;
          end
        end
      end
      S_MISAL: begin
        if (bus.trap_taken_in) begin
          pc_d    = bus.trap_addr_in;
          flush_d = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign bus.imem_req_out         = (state_q == S_REQ) && started_q;
  assign bus.imem_addr_out        = pc_q;
  assign bus.instr_valid_out      = (state_q == S_HOLD);
  assign bus.instr_out            = instr_q;
  assign bus.pc_out               = pc_out_q;
  assign bus.flush_out            = flush_q;
  assign bus.misaligned_instr_out = (state_q == S_MISAL);
  assign bus.state_dbg            = state_q;

endmodule

// File: tb/tb_msrv32_fetch_unit.sv
// Self-checking bench for msrv32_fetch_unit: memory responder, decode driver,
// address/pc scoreboard queues and a one-line summary.
module tb_msrv32_fetch_unit;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_MISAL = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msrv32_fetch_unit_if bus();

  msrv32_fetch_unit #(.BOOT_ADDR(32'h0000_0000), .PC_INC(32'd4)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .bus                    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int flush_cnt = 0;
  bit prev_flush = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  // memory responder controls
  bit          gnt_en = 1'b1;
  int          rsp_delay = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          force_data = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"},   32'(bus.imem_req_out), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.instr_valid_out), 32'd0);
    check_eq({tag, "_flush"}, 32'(bus.flush_out), 32'd0);
    check_eq({tag, "_misal"}, 32'(bus.misaligned_instr_out), 32'd0);
    check_eq({tag, "_instr"}, bus.instr_out, 32'h0000_0013);
    check_eq({tag, "_state"}, 32'(bus.state_dbg), 32'(S_REQ));
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (bus.state_dbg == target) hit = 1'b1;
    end
    if (!hit) check_eq({tag, "_timeout"}, 32'(bus.state_dbg), 32'(target));
  endtask

  // Waits for HOLD, scores the held instruction, then performs one handshake.
  task automatic accept(input logic br, input logic [31:0] ia, input logic tr,
                        input logic [31:0] ta, input string tag);
    logic [31:0] exp_pc;
    wait_state(S_HOLD, 40, tag);
    if (exp_pc_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_pc: got %h expected no instruction", tag, bus.pc_out);
    end else begin
      exp_pc = exp_pc_q.pop_front();
      check_eq({tag, "_pc"}, bus.pc_out, exp_pc);
      check_eq({tag, "_instr"}, bus.instr_out, mem_word(exp_pc));
    end
    bus.instr_ready_in  = 1'b1;
    bus.branch_taken_in = br;
    bus.iaddr_in        = ia;
    bus.trap_taken_in   = tr;
    bus.trap_addr_in    = ta;
    @(posedge clk); #1;
    bus.instr_ready_in  = 1'b0;
    bus.branch_taken_in = 1'b0;
    bus.iaddr_in        = 32'h0;
    bus.trap_taken_in   = 1'b0;
    bus.trap_addr_in    = 32'h0;
  endtask

  task automatic pulse_trap(input logic [31:0] ta);
    bus.trap_taken_in = 1'b1;
    bus.trap_addr_in  = ta;
    @(posedge clk); #1;
    bus.trap_taken_in = 1'b0;
    bus.trap_addr_in  = 32'h0;
  endtask

  // instruction memory: grants a request immediately, answers rsp_delay cycles later
  initial begin
    bus.imem_gnt_in    = 1'b0;
    bus.imem_rvalid_in = 1'b0;
    bus.imem_rdata_in  = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.imem_gnt_in    = 1'b0;
      bus.imem_rvalid_in = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.imem_rvalid_in = 1'b1;
          bus.imem_rdata_in  = force_data ? 32'hDEAD_BEEF : mem_word(pend_addr);
        end
      end else if (bus.imem_req_out && gnt_en) begin
        bus.imem_gnt_in = 1'b1;
        pend_addr       = bus.imem_addr_out;
        pend_cnt        = rsp_delay;
      end
    end
  end

  // fetch-address scoreboard and flush monitor
  always @(negedge clk) begin
    if (bus.imem_req_out && bus.imem_gnt_in) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fetch_addr: got %h expected no request", bus.imem_addr_out);
      end else begin
        check_eq("fetch_addr", bus.imem_addr_out, exp_addr_q.pop_front());
      end
    end
    if (bus.flush_out) begin
      flush_cnt++;
      check_eq("flush_one_cycle", 32'(prev_flush), 32'd0);
      check_eq("valid_with_flush", 32'(bus.instr_valid_out), 32'd0);
    end
    prev_flush = bus.flush_out;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb;
    bit seen;
    bus.branch_taken_in = 1'b0;
    bus.iaddr_in        = 32'h0;
    bus.trap_taken_in   = 1'b0;
    bus.trap_addr_in    = 32'h0;
    bus.instr_ready_in  = 1'b0;

    // 1: reset values, sequential fetch from BOOT_ADDR
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("t1_reset");
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'h100);
    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    exp_pc_q.push_back(32'h8);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t1_first_req", 32'(bus.imem_req_out), 32'd1);
    accept(1'b0, 32'h0, 1'b0, 32'h0, "t1a");
    accept(1'b0, 32'h0, 1'b0, 32'h0, "t1b");
    check_eq("t1_no_flush", 32'(flush_cnt), 32'd0);

    // 2: taken branch to an odd address clears bit 0
    accept(1'b1, 32'h0000_0101, 1'b0, 32'h0, "t2");
    @(negedge clk);
    check_eq("t2_flush_hi", 32'(bus.flush_out), 32'd1);
    @(negedge clk);
    check_eq("t2_flush_lo", 32'(bus.flush_out), 32'd0);
    exp_pc_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    exp_addr_q.push_back(32'h8000_0000);
    rsp_delay = 4;

    // 3: trap while waiting kills the in-flight response
    accept(1'b0, 32'h0, 1'b0, 32'h0, "t2b");
    wait_state(S_WAIT, 20, "t3_wait");
    fb = flush_cnt;
    force_data = 1'b1;
    pulse_trap(32'h8000_0000);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      check_eq("t3_no_valid", 32'(bus.instr_valid_out), 32'd0);
      if (bus.imem_rvalid_in) seen = 1'b1;
    end
    if (!seen) check_eq("t3_rvalid_timeout", 32'(seen), 32'd1);
    force_data = 1'b0;
    rsp_delay = 1;
    @(negedge clk);
    check_eq("t3_dropped", 32'(bus.instr_valid_out), 32'd0);
    check_eq("t3_flush_cnt", 32'(flush_cnt - fb), 32'd1);
    exp_pc_q.push_back(32'h8000_0000);
    exp_pc_q.push_back(32'h8000_0004);
    exp_addr_q.push_back(32'h8000_0004);
    accept(1'b0, 32'h0, 1'b0, 32'h0, "t3b");

    // 4: misaligned branch target parks the unit until a trap
    fb = flush_cnt;
    accept(1'b1, 32'h0000_0202, 1'b0, 32'h0, "t4");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_misal", 32'(bus.misaligned_instr_out), 32'd1);
      check_eq("t4_no_req", 32'(bus.imem_req_out), 32'd0);
      check_eq("t4_no_valid", 32'(bus.instr_valid_out), 32'd0);
    end
    check_eq("t4_no_flush", 32'(flush_cnt - fb), 32'd0);
    exp_addr_q.push_back(32'h100);
    pulse_trap(32'h100);
    @(negedge clk);
    check_eq("t4_misal_clr", 32'(bus.misaligned_instr_out), 32'd0);
    check_eq("t4_flush", 32'(bus.flush_out), 32'd1);
    check_eq("t4_addr", bus.imem_addr_out, 32'h100);

    // 5: stalled decode holds the instruction; trap beats branch on release
    exp_pc_q.push_back(32'h100);
    wait_state(S_HOLD, 20, "t5_hold");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t5_instr_stable", bus.instr_out, mem_word(32'h100));
      check_eq("t5_pc_stable", bus.pc_out, 32'h100);
      check_eq("t5_no_req", 32'(bus.imem_req_out), 32'd0);
    end
    fb = flush_cnt;
    exp_addr_q.push_back(32'h200);
    accept(1'b1, 32'h300, 1'b1, 32'h200, "t5");
    exp_pc_q.push_back(32'h200);
    exp_addr_q.push_back(32'h204);
    rsp_delay = 6;

    // 6: reset during WAIT; the stale response must be ignored
    accept(1'b0, 32'h0, 1'b0, 32'h0, "t6a");
    check_eq("t5_flush_cnt", 32'(flush_cnt - fb), 32'd1);
    wait_state(S_WAIT, 20, "t6_wait");
    rst_n = 1'b0;
    #1;
    check_reset("t6_reset_now");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("t6_reset_held");
    exp_addr_q.push_back(32'h0);
    exp_pc_q.push_back(32'h0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      check_eq("t6_no_valid", 32'(bus.instr_valid_out), 32'd0);
      if (bus.imem_rvalid_in) seen = 1'b1;
    end
    if (!seen) check_eq("t6_stale_timeout", 32'(seen), 32'd1);
    rsp_delay = 1;
    wait_state(S_HOLD, 20, "t6_hold");
    gnt_en = 1'b0;
    accept(1'b0, 32'h0, 1'b0, 32'h0, "t6b");

    // 7: trap in REQ before grant, then PC wraps past 0xFFFF_FFFC
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_pc_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'h0);
    fb = flush_cnt;
    @(negedge clk);
    check_eq("t7_req_pending", 32'(bus.imem_req_out), 32'd1);
    check_eq("t7_addr_before", bus.imem_addr_out, 32'h4);
    pulse_trap(32'hFFFF_FFFC);
    @(negedge clk);
    check_eq("t7_addr_after", bus.imem_addr_out, 32'hFFFF_FFFC);
    check_eq("t7_flush", 32'(bus.flush_out), 32'd1);
    gnt_en = 1'b1;
    accept(1'b0, 32'h0, 1'b0, 32'h0, "t7a");
    accept(1'b0, 32'h0, 1'b0, 32'h0, "t7b");
    repeat (4) @(negedge clk);
    check_eq("t7_flush_cnt", 32'(flush_cnt - fb), 32'd1);
    check_eq("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check_eq("pc_q_drained", 32'(exp_pc_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/msrv32_fetch_unit.md
Name: msrv32_fetch_unit

Overview:
Instruction fetch and program-counter unit for the msrv32 core. It consumes the branch_taken decision and resolved target from the branch unit, plus trap redirects from machine control. It drives a single-outstanding-request instruction-memory handshake and hands each fetched instruction to decode with a valid/ready pair. It also flags misaligned branch targets and produces the pipeline flush pulse on every redirect.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value loaded on reset
PC_INC, 32'd4, sequential PC increment

Ports:
ms_riscv32_mp_clk_in  input  1  core clock, rising edge
ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous, active-low
branch_taken_in  input  1  from branch unit; sampled only on decode handshake
iaddr_in  input  32  resolved branch/jump target
trap_taken_in  input  1  trap/mret redirect; highest priority, sampled every cycle
trap_addr_in  input  32  trap/return target, word aligned
imem_req_out  output  1  fetch request
imem_addr_out  output  32  fetch address
imem_gnt_in  input  1  request accepted
imem_rvalid_in  input  1  read data valid, one cycle
imem_rdata_in  input  32  instruction word
instr_valid_out  output  1  instr_out/pc_out valid
instr_ready_in  input  1  decode accepts instruction
instr_out  output  32  held instruction
pc_out  output  32  address of instr_out
flush_out  output  1  one-cycle redirect pulse
misaligned_instr_out  output  1  taken target not 4-byte aligned; held until trap

Behaviour:
- Clock and reset: single clock ms_riscv32_mp_clk_in. Reset ms_riscv32_mp_rst_n_in is asynchronous and active-low.
- Reset values (immediate on assertion, regardless of state):
  - pc = BOOT_ADDR; state = REQ.
  - imem_req_out, instr_valid_out, flush_out, misaligned_instr_out = 0.
  - instr_out = 32'h0000_0013 (NOP).
  - Kill flag = 0.
  - An outstanding request is abandoned; a response arriving after reset is ignored.
- imem_req_out first rises in the first cycle after reset deasserts.
- imem_addr_out = pc whenever imem_req_out = 1.
- Redirect priority, applied on the handshake (HOLD and instr_ready_in):
  1. trap_taken_in → pc = trap_addr_in.
  2. branch_taken_in and iaddr_in[1] = 1 → go to MISAL.
  3. branch_taken_in → pc = {iaddr_in[31:1], 1'b0}.
  4. Otherwise pc = pc + PC_INC. Wraps mod 2^32; 32'hFFFF_FFFC + 4 = 0, no flag.
- States:
  - REQ: imem_req_out = 1.
    - imem_gnt_in → WAIT.
    - trap_taken_in without gnt → pc = trap_addr_in, stay REQ. The address may change before grant.
    - trap_taken_in with gnt in the same cycle → WAIT with kill = 1, pc = trap_addr_in.
  - WAIT: imem_req_out = 0.
    - imem_rvalid_in with kill = 0 → instr_out = imem_rdata_in, pc_out = pc, go to HOLD.
    - imem_rvalid_in with kill = 1 → drop data, clear kill, go to REQ.
    - trap_taken_in → kill = 1, pc = trap_addr_in. If rvalid arrives in the same cycle, the data is dropped.
  - HOLD: instr_valid_out = 1. instr_out and pc_out stay stable until the handshake.
    - Handshake → apply the priority list above, then REQ.
    - trap_taken_in without ready → drop instruction, pc = trap_addr_in, go to REQ.
  - MISAL: instr_valid_out = 0, imem_req_out = 0, misaligned_instr_out = 1. Leaves only on trap_taken_in: pc = trap_addr_in, clear flag, go to REQ.
- flush_out: registered; high for exactly the one cycle after any trap or taken-branch redirect is applied. No flush on sequential advance or on entering MISAL.
- Latency:
  - Zero-wait memory (gnt in REQ, rvalid the next cycle): instr_valid_out rises 2 cycles after entering REQ.
  - Throughput is 1 instruction per 3 cycles when instr_ready_in is held high.
- instr_valid_out never rises in the same cycle as flush_out.

Test Plan:
1. Reset release, zero-wait memory, instr_ready_in = 1 → imem_addr_out sequence 0x0, 0x4, 0x8. pc_out matches each instruction. flush_out stays 0.
2. Instr at 0x8 accepted with branch_taken_in = 1, iaddr_in = 0x0000_0101 → next imem_addr_out = 0x0000_0100. flush_out pulses for 1 cycle.
3. WAIT state with trap_taken_in = 1, trap_addr_in = 0x8000_0000, rvalid arriving 3 cycles later with 0xDEADBEEF → data dropped, instr_valid_out stays 0. Next request address = 0x8000_0000.
4. Accepted branch with iaddr_in = 0x0000_0202 → misaligned_instr_out = 1, no requests for 5 cycles. trap_taken_in, trap_addr_in = 0x100 → flag clears and the fetch address is 0x100.
5. instr_ready_in held 0 for 4 cycles in HOLD → instr_out and pc_out stable, no new request. Release with branch_taken_in = 1 and trap_taken_in = 1 (trap_addr_in = 0x200, iaddr_in = 0x300) → trap wins, fetch address = 0x200.
6. Assert reset in WAIT, deassert 2 cycles later, then a stale rvalid arrives → outputs at reset values. The stale response is ignored. First address after reset = BOOT_ADDR.
